jtag_regbank: RTL
=================

JTAG_REGBANK -- requirements
Module: jtag_regbank

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32: bit width of every channel register.
REQ-002 The module SHALL have parameter NUM_CHANNELS, default 16, legal range 1..256: number of input and output channels.
REQ-003 The module SHALL have port iMAIN_CLK  input  1  single clock; all logic on its rising edge.
REQ-004 The module SHALL have port iRESET  input  1  synchronous active-high reset.
REQ-005 The module SHALL have port iCMD_VALID  input  1  command present.
REQ-006 The module SHALL have port oCMD_READY  output  1  command accepted when high together with iCMD_VALID.
REQ-007 The module SHALL have port iCMD_OP  input  2  opcode: 00 read input channel, 01 write output channel, 10 snapshot, 11 read back output channel.
REQ-008 The module SHALL have port iCMD_ADDR  input  8  channel index.
REQ-009 The module SHALL have port iCMD_WDATA  input  WIDTH  write data.
REQ-010 The module SHALL have port oRSP_VALID  output  1  response present.
REQ-011 The module SHALL have port iRSP_READY  input  1  response consumed when high together with oRSP_VALID.
REQ-012 The module SHALL have port oRSP_DATA  output  WIDTH  response data.
REQ-013 The module SHALL have port oRSP_ERR  output  1  address-out-of-range flag.
REQ-014 The module SHALL have port iDATA  input  NUM_CHANNELS*WIDTH  flattened input channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-015 The module SHALL have port oDATA  output  NUM_CHANNELS*WIDTH  flattened output channel registers, same packing.
REQ-016 The module SHALL have port oUPDATE  output  NUM_CHANNELS  one-cycle write strobe per channel.

Function
REQ-017 The controller SHALL be an FSM with states IDLE, EXEC, RESP; oCMD_READY SHALL be high only in IDLE.
REQ-018 On accept, the FSM SHALL register op, addr and wdata and go IDLE->EXEC; EXEC->RESP unconditionally after one cycle; RESP->IDLE on iRSP_READY.
REQ-019 oRSP_VALID SHALL be high exactly in RESP, rising 2 cycles after the accept edge; oRSP_DATA and oRSP_ERR SHALL be stable while oRSP_VALID is high.
REQ-020 An address >= NUM_CHANNELS with op 00, 01 or 11 SHALL set oRSP_ERR=1 and oRSP_DATA=0, with no change to oDATA or oUPDATE.
REQ-021 A valid write SHALL load channel addr of oDATA at the end of EXEC, and oUPDATE[addr] SHALL be high for exactly the cycle after that edge; oRSP_DATA SHALL equal the written value.
REQ-022 A read-back (11) SHALL return the current oDATA channel addr.
REQ-023 A snapshot (10) SHALL ignore iCMD_ADDR, never error, and return oRSP_DATA = NUM_CHANNELS zero-extended to WIDTH.
REQ-024 Back-to-back commands SHALL sustain one command per 3 cycles when iRSP_READY is held high; at most one command SHALL be outstanding.
REQ-025 iCMD_* SHALL be ignored while oCMD_READY is low.

Reset
REQ-026 With iRESET high at an edge, the FSM SHALL enter IDLE, and oRSP_VALID, oRSP_ERR, oRSP_DATA, oDATA, oUPDATE and snapshot registers SHALL become 0.
REQ-027 Reset in EXEC or RESP SHALL abort the command without committing a pending write; oCMD_READY SHALL be 1 in the first cycle after reset release.

Configuration
REQ-028 With macro JTAG_REGBANK_SNAPSHOT_EN defined, op 10 SHALL capture all iDATA channels into a snapshot array in EXEC, and op 00 SHALL return the snapshot entry.
REQ-029 Without JTAG_REGBANK_SNAPSHOT_EN, no snapshot array SHALL exist, op 00 SHALL return iDATA channel addr sampled in EXEC, and op 10 SHALL complete as a no-op with the REQ-023 response.

Verification
REQ-030 Reset, then write op 01, addr 3, data 0xDEADBEEF -> oUPDATE=0x0008 for one cycle; oDATA ch3=0xDEADBEEF; response 0xDEADBEEF with err 0.
REQ-031 Read-back op 11, addr 3 -> 0xDEADBEEF; op 00, addr 16 with NUM_CHANNELS=16 -> err 1, data 0, oDATA unchanged.
REQ-032 With SNAPSHOT_EN, set iDATA ch5=0x11, snapshot, change ch5 to 0x22, read addr 5 -> 0x11; without the macro -> 0x22.
REQ-033 Hold iRSP_READY low 10 cycles -> oRSP_VALID held and data stable, oCMD_READY low; release -> IDLE next cycle.
REQ-034 Assert iRESET in the EXEC cycle of a write to addr 0 -> oDATA ch0 stays 0, no oUPDATE pulse, no response.
REQ-035 Issue 4 writes with iCMD_VALID and iRSP_READY held high -> accepts 3 cycles apart, all 4 responses in order.

Source files
------------

// File: rtl/jtag_regbank_if.sv
// ----------------------------------------------------------------------------
// jtag_regbank_if -- command/response bus of the JTAG register bank.
//
// Command channel (valid/ready):
//   iCMD_VALID  requester has a command
//   oCMD_READY  bank can accept a command
//   iCMD_OP     00 read input, 01 write output, 10 snapshot, 11 read back output
//   iCMD_ADDR   channel index
//   iCMD_WDATA  write data
// Response channel (valid/ready):
//   oRSP_VALID  response present
//   iRSP_READY  requester consumes the response
//   oRSP_DATA   response data
//   oRSP_ERR    channel index out of range
//
// master: the requester side.  slave: the register bank.
// ----------------------------------------------------------------------------
interface jtag_regbank_if #(
  parameter int WIDTH = 32
);
  logic             iCMD_VALID;
  logic             oCMD_READY;
  logic [1:0]       iCMD_OP;
  logic [7:0]       iCMD_ADDR;
  logic [WIDTH-1:0] iCMD_WDATA;
  logic             oRSP_VALID;
  logic             iRSP_READY;
  logic [WIDTH-1:0] oRSP_DATA;
  logic             oRSP_ERR;

  modport master (
    output iCMD_VALID, iCMD_OP, iCMD_ADDR, iCMD_WDATA, iRSP_READY,
    input  oCMD_READY, oRSP_VALID, oRSP_DATA, oRSP_ERR
  );

  modport slave (
    input  iCMD_VALID, iCMD_OP, iCMD_ADDR, iCMD_WDATA, iRSP_READY,
    output oCMD_READY, oRSP_VALID, oRSP_DATA, oRSP_ERR
  );
endinterface

// File: rtl/jtag_regbank.sv
// ----------------------------------------------------------------------------
// jtag_regbank -- bank of NUM_CHANNELS output registers and NUM_CHANNELS
// input channels, driven one command at a time through a valid/ready
// command/response bus (typically from a JTAG-to-bus bridge).
//
// Ports:
//   iMAIN_CLK  single clock, rising edge
//   iRESET     synchronous active-high reset
//   bus        jtag_regbank_if.slave command/response bus
//   iDATA      flattened input channels,  channel k at [k*WIDTH +: WIDTH]
//   oDATA      flattened output registers, same packing
//   oUPDATE    one-cycle strobe per output channel, high the cycle after a write
//
// Controller: IDLE (accept) -> EXEC (perform) -> RESP (hold until consumed).
//
// Build option: define JTAG_REGBANK_SNAPSHOT_EN to add a snapshot array.
// With it, op 10 captures every input channel and op 00 reads the captured
// copy; without it, op 00 reads the live input and op 10 is a no-op.
// Op 10 always answers with NUM_CHANNELS and never flags an error.
// ----------------------------------------------------------------------------
module jtag_regbank #(
  parameter int WIDTH        = 32,
  parameter int NUM_CHANNELS = 16
) (
  input  logic                          iMAIN_CLK,
  input  logic                          iRESET,
  jtag_regbank_if.slave                 bus,
  input  logic [NUM_CHANNELS*WIDTH-1:0] iDATA,
  output logic [NUM_CHANNELS*WIDTH-1:0] oDATA,
  output logic [NUM_CHANNELS-1:0]       oUPDATE
);

  localparam int IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} stateT;

  typedef enum logic [1:0] {
    OP_READ_IN   = 2'b00,
    OP_WRITE_OUT = 2'b01,
    OP_SNAPSHOT  = 2'b10,
    OP_READ_BACK = 2'b11
  } opT;

  stateT            state, stateNext;
  opT               opReg;
  logic [7:0]       addrReg;
  logic [WIDTH-1:0] wdataReg;
  logic [WIDTH-1:0] rspData;
  logic             rspErr;

  logic [WIDTH-1:0] outReg [NUM_CHANNELS];
  logic [WIDTH-1:0] inCh   [NUM_CHANNELS];

  logic             accept;
  logic             inRange;
  logic [IDX_W-1:0] chIdx;
  logic [WIDTH-1:0] execData;
  logic             execErr;
  logic             execWrite;

`ifdef JTAG_REGBANK_SNAPSHOT_EN
  logic [WIDTH-1:0] snapReg [NUM_CHANNELS];
  logic             execSnap;
`endif

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : gChan
    assign inCh[k]                   = iDATA[k*WIDTH +: WIDTH];
    assign oDATA[k*WIDTH +: WIDTH]   = outReg[k];
  end

  assign accept         = bus.iCMD_VALID && (state == IDLE);
  assign inRange        = int'(addrReg) < NUM_CHANNELS;
  assign chIdx          = addrReg[IDX_W-1:0];

  assign bus.oCMD_READY = (state == IDLE);
  assign bus.oRSP_VALID = (state == RESP);
  assign bus.oRSP_DATA  = rspData;
  assign bus.oRSP_ERR   = rspErr;

  // Next state plus the result of the registered command. The result is
  // only committed on the EXEC edge; side effects are qualified by EXEC here.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    stateNext = state;
    execData  = '0;
    execErr   = 1'b0;
    execWrite = 1'b0;
`ifdef JTAG_REGBANK_SNAPSHOT_EN
    execSnap  = 1'b0;
`endif

    case (state)
      IDLE:    if (accept) stateNext = EXEC;
      EXEC:    stateNext = RESP;
      RESP:    if (bus.iRSP_READY) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase

    case (opReg)
      OP_READ_IN: begin
        if (inRange) begin
`ifdef JTAG_REGBANK_SNAPSHOT_EN
          execData = snapReg[chIdx];
`else
          execData = inCh[chIdx];
`endif
        end else begin
          execErr = 1'b1;
        end
      end
      OP_WRITE_OUT: begin
        if (inRange) begin
          execData  = wdataReg;
          execWrite = (state == EXEC);
        end else begin
          execErr = 1'b1;
        end
      end
      OP_SNAPSHOT: begin
        // The channel count doubles as a capability word for the host.
        execData = WIDTH'(NUM_CHANNELS);
`ifdef JTAG_REGBANK_SNAPSHOT_EN
        execSnap = (state == EXEC);
`endif
      end
      OP_READ_BACK: begin
        if (inRange) execData = outReg[chIdx];
        else         execErr  = 1'b1;
      end
      default: execErr = 1'b1;
    endcase
  end

  always_ff @(posedge iMAIN_CLK) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (iRESET) begin
      state    <= IDLE;
      opReg    <= OP_READ_IN;
      addrReg  <= '0;
      wdataReg <= '0;
      rspData  <= '0;
      rspErr   <= 1'b0;
      oUPDATE  <= '0;
      // NOTE: the channel arrays are reset because they drive oDATA and the
      // snapshot read path directly; a plain storage RAM would not be.
      for (int k = 0; k < NUM_CHANNELS; k++) begin
        outReg[k] <= '0;
`ifdef JTAG_REGBANK_SNAPSHOT_EN
        snapReg[k] <= '0;
`endif
      end
    end else begin
      state   <= stateNext;
      oUPDATE <= '0;

      if (accept) begin
        opReg    <= opT'(bus.iCMD_OP);
        addrReg  <= bus.iCMD_ADDR;
        wdataReg <= bus.iCMD_WDATA;
      end

      // Response registers load once and then hold for the whole RESP phase.
      if (state == EXEC) begin
        rspData <= execData;
        rspErr  <= execErr;
      end

      if (execWrite) begin
        outReg[chIdx]  <= wdataReg;
        oUPDATE[chIdx] <= 1'b1;
      end

`ifdef JTAG_REGBANK_SNAPSHOT_EN
      if (execSnap) begin
        for (int k = 0; k < NUM_CHANNELS; k++) snapReg[k] <= inCh[k];
      end
`endif
    end
  end

endmodule
